// File: rtl/load_cell_monitor.sv
// load_cell_monitor: producer side of the steering-enable interface.
// Filters left/right load-cell readings, derives rider-weight and balance
// flags with hysteresis, and owns the 1.3 s qualification timer.
// Optional build macro FAST_SIM_EN: shortens the timer terminal count to 4096.
module load_cell_monitor #(
  parameter int unsigned       LC_W             = 12,
  parameter logic [12:0]       MIN_RIDER_WEIGHT = 13'h0200,
  parameter logic [12:0]       HYSTERESIS       = 13'h0040,
  parameter int unsigned       TMR_W            = 26,
  parameter logic [TMR_W-1:0]  TMR_FULL_CNT     = 26'd65_000_000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            vld,
  input  logic [LC_W-1:0] lft_ld,
  input  logic [LC_W-1:0] rght_ld,
  input  logic            clr_tmr,
  output logic            sum_gt_min,
  output logic            sum_lt_min,
  output logic            diff_gt_1_4,
  output logic            diff_gt_15_16,
  output logic            tmr_full
);

  localparam int unsigned SUM_W = LC_W + 1;
  localparam int unsigned ACC_W = LC_W + 2;

  localparam logic [SUM_W-1:0] SUM_HI = SUM_W'(MIN_RIDER_WEIGHT + HYSTERESIS);
  localparam logic [SUM_W-1:0] SUM_LO = SUM_W'(MIN_RIDER_WEIGHT - HYSTERESIS);

`ifdef FAST_SIM_EN
  localparam logic [TMR_W-1:0] TERM_CNT = TMR_W'(4096);
`else
  localparam logic [TMR_W-1:0] TERM_CNT = TMR_FULL_CNT;
`endif

  logic [ACC_W-1:0] acc_l, acc_r;
  logic [ACC_W-1:0] acc_l_nxt, acc_r_nxt;
  logic             primed;
  logic             upd;

  logic [LC_W-1:0]  filt_l, filt_r;
  logic [SUM_W-1:0] sum, q, f;
  logic [LC_W-1:0]  diff;

  logic [TMR_W-1:0] cnt;

  // Next accumulator values: load on first sample, leaky integrate afterwards
  always_comb begin
    acc_l_nxt = acc_l;
    acc_r_nxt = acc_r;
    if (primed) begin
      acc_l_nxt = (acc_l - (acc_l >> 2)) + {2'b00, lft_ld};
      acc_r_nxt = (acc_r - (acc_r >> 2)) + {2'b00, rght_ld};
    end else begin
      acc_l_nxt = {lft_ld, 2'b00};
      acc_r_nxt = {rght_ld, 2'b00};
    end
  end

  // Filter state and the one-cycle-delayed flag update strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_l  <= '0;
      acc_r  <= '0;
      primed <= 1'b0;
      upd    <= 1'b0;
    end else begin
      upd <= vld;
      if (vld) begin
        acc_l  <= acc_l_nxt;
        acc_r  <= acc_r_nxt;
        primed <= 1'b1;
      end
    end
  end

  // Filtered sum, absolute difference and the two balance thresholds
  always_comb begin
    filt_l = acc_l[ACC_W-1:2];
    filt_r = acc_r[ACC_W-1:2];
    sum    = {1'b0, filt_l} + {1'b0, filt_r};
    diff   = (filt_l >= filt_r) ? (filt_l - filt_r) : (filt_r - filt_l);
    q      = sum >> 2;
    f      = sum - (sum >> 4);
  end

  // Comparator flags, refreshed only on the cycle after a sample
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_gt_min    <= 1'b0;
      sum_lt_min    <= 1'b1;
      diff_gt_1_4   <= 1'b0;
      diff_gt_15_16 <= 1'b0;
    end else if (upd) begin
      sum_gt_min    <= (sum > SUM_HI);
      sum_lt_min    <= (sum < SUM_LO);
      diff_gt_1_4   <= ({1'b0, diff} > q);
      diff_gt_15_16 <= ({1'b0, diff} > f);
    end
  end

  // Qualification timer: clear beats saturate beats increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr_tmr) begin
      cnt <= '0;
    end else if (cnt != TERM_CNT) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tmr_full = (cnt == TERM_CNT);

endmodule
